// File: rtl/dac_pkg.sv
// dac_pkg: shared sizes and run-state encoding
// for the DAC stream generator.
package dac_pkg;
  localparam int N_DAC    = 16;
  localparam int DAC_BITS = 16;
  localparam int BITS     = N_DAC * DAC_BITS;
  localparam int TBL_AW   = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH
  } state_t;
endpackage

// File: rtl/dac_stream_gen_if.sv
// dac_stream_gen_if: AXI-stream style beat bundle
// with producer (master) and consumer (slave) views.
interface dac_stream_gen_if #(
  parameter int BITS = dac_pkg::BITS
) ();
  logic [BITS-1:0] tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_out_reg.sv
// axis_out_reg: one-entry output register; a beat
// stays put until the sink accepts it.
module axis_out_reg #(
  parameter int BITS = dac_pkg::BITS
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_load,
  input  logic [BITS-1:0] i_data,
  input  logic            i_last,
  output logic            o_free,
  dac_stream_gen_if.master m
);
  logic            r_valid;
  logic            r_last;
  logic [BITS-1:0] r_data;
  logic            w_ld;

  assign o_free = !r_valid || m.tready;
  assign w_ld   = i_load && o_free;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (w_ld) begin
      r_valid <= 1'b1;
      r_last  <= i_last;
      r_data  <= i_data;
    end else if (m.tready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign m.tdata  = r_data;
  assign m.tvalid = r_valid;
  assign m.tlast  = r_last;
endmodule

// File: rtl/dac_stream_gen.sv
// dac_stream_gen: table-driven multi-lane DAC
// stream with per-lane phase offsets.
module dac_stream_gen #(
  parameter int N_DAC    = dac_pkg::N_DAC,
  parameter int DAC_BITS = dac_pkg::DAC_BITS,
  parameter int BITS     = dac_pkg::BITS,
  parameter int TBL_AW   = dac_pkg::TBL_AW
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                tbl_we,
  input  logic [TBL_AW-1:0]   tbl_waddr,
  input  logic [DAC_BITS-1:0] tbl_wdata,
  input  logic                start,
  input  logic                stop,
  input  logic [TBL_AW-1:0]   period,
  input  logic [15:0]         n_periods,
  input  logic [TBL_AW-1:0]   lane_step,
  input  logic [N_DAC-1:0]    ch_mask,
  output logic [BITS-1:0]     m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                done
);
  import dac_pkg::*;

  localparam int CW = (N_DAC > 1) ? $clog2(N_DAC) : 1;
  localparam int PW = TBL_AW + 1;

  state_t r_state, w_state;

  logic [TBL_AW-1:0]   r_per;
  logic [TBL_AW-1:0]   r_step;
  logic [15:0]         r_nper;
  logic [15:0]         r_pcnt;
  logic [N_DAC-1:0]    r_mask;
  logic [TBL_AW-1:0]   r_ptr [N_DAC];
  logic [CW-1:0]       r_icnt;
  logic                r_done;
  logic [DAC_BITS-1:0] r_tbl [2**TBL_AW];

  logic              w_free;
  logic              w_load;
  logic              w_wrap;
  logic              w_last;
  logic              w_init_end;
  logic              w_flush_end;
  logic [TBL_AW-1:0] w_per_in;
  logic [PW-1:0]     w_sum;
  logic [TBL_AW-1:0] w_iptr;
  logic [BITS-1:0]   w_data;

  dac_stream_gen_if #(.BITS(BITS)) u_axis ();

  assign w_per_in    = (period == '0) ? TBL_AW'(1) : period;
  assign w_load      = (r_state == S_RUN) && !stop && w_free;
  assign w_wrap      = r_ptr[0] == r_per - TBL_AW'(1);
  assign w_last      = w_wrap && (r_nper != '0) &&
                       (r_pcnt == r_nper - 16'd1);
  assign w_init_end  = r_icnt == CW'(N_DAC - 1);
  assign w_flush_end = !u_axis.tvalid || u_axis.tready;

  // Lane c sits one step ahead of lane c-1, modulo the period.
  assign w_sum  = {1'b0, r_ptr[r_icnt - CW'(1)]} + {1'b0, r_step};
  assign w_iptr = (w_sum >= {1'b0, r_per}) ?
                  TBL_AW'(w_sum - {1'b0, r_per}) :
                  TBL_AW'(w_sum);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state;
  end

  always_comb begin
    w_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state = S_INIT;
      S_INIT:  if (w_init_end) w_state = S_RUN;
      S_RUN:   if (stop || (w_load && w_last))
                 w_state = S_FLUSH;
      S_FLUSH: if (w_flush_end) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_per  <= '0;
      r_step <= '0;
      r_nper <= '0;
      r_pcnt <= '0;
      r_mask <= '0;
      r_icnt <= '0;
      r_done <= 1'b0;
      for (int j = 0; j < N_DAC; j++) r_ptr[j] <= '0;
    end else begin
      r_done <= (r_state == S_FLUSH) && w_flush_end;
      unique case (1'b1)
        (r_state == S_IDLE) && start: begin
          r_per    <= w_per_in;
          r_step   <= (lane_step < w_per_in) ? lane_step : '0;
          r_nper   <= n_periods;
          r_mask   <= ch_mask;
          r_pcnt   <= '0;
          r_icnt   <= CW'(1);
          r_ptr[0] <= '0;
        end
        r_state == S_INIT: begin
          r_ptr[r_icnt] <= w_iptr;
          r_icnt        <= r_icnt + CW'(1);
        end
        w_load: begin
          for (int j = 0; j < N_DAC; j++)
            r_ptr[j] <= (r_ptr[j] == r_per - TBL_AW'(1)) ?
                        '0 : r_ptr[j] + TBL_AW'(1);
          if (w_wrap) r_pcnt <= r_pcnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Sample table is not reset; its contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (tbl_we) r_tbl[tbl_waddr] <= tbl_wdata;
  end

  always_comb begin
    w_data = '0;
    for (int j = 0; j < N_DAC; j++)
      if (r_mask[j])
        w_data[j*DAC_BITS +: DAC_BITS] = r_tbl[r_ptr[j]];
  end

  axis_out_reg #(.BITS(BITS)) u_out (
    .clk     (clk),
    .aresetn (aresetn),
    .i_load  (w_load),
    .i_data  (w_data),
    .i_last  (w_last),
    .o_free  (w_free),
    .m       (u_axis)
  );

  assign u_axis.tready = m_axis_tready;
  assign m_axis_tdata  = u_axis.tdata;
  assign m_axis_tvalid = u_axis.tvalid;
  assign m_axis_tlast  = u_axis.tlast;
  assign busy          = r_state != S_IDLE;
  assign done          = r_done;
endmodule

// File: tb/tb_dac_stream_gen.sv
// tb_dac_stream_gen: randomized scenarios checked
// against an arithmetic lane/phase model.
module tb_dac_stream_gen;
  localparam int ND = 16;
  localparam int DB = 16;
  localparam int BW = 256;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_waddr = '0;
  logic [DB-1:0] tbl_wdata = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] period = '0;
  logic [15:0]   n_periods = '0;
  logic [AW-1:0] lane_step = '0;
  logic [ND-1:0] ch_mask = '0;
  logic          busy;
  logic          done;

  dac_stream_gen_if #(.BITS(BW)) axis ();

  dac_stream_gen u_dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .tbl_we        (tbl_we),
    .tbl_waddr     (tbl_waddr),
    .tbl_wdata     (tbl_wdata),
    .start         (start),
    .stop          (stop),
    .period        (period),
    .n_periods     (n_periods),
    .lane_step     (lane_step),
    .ch_mask       (ch_mask),
    .m_axis_tdata  (axis.tdata),
    .m_axis_tvalid (axis.tvalid),
    .m_axis_tready (axis.tready),
    .m_axis_tlast  (axis.tlast),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DB-1:0] mdl_tbl [128];
  int            m_per, m_np, m_step;
  logic [ND-1:0] m_mask;

  logic [BW-1:0] q_d [$];
  bit            q_l [$];
  int done_cnt, stab_err, cyc, last_cyc, done_cyc;
  int rdy_mode = 0;

  function automatic logic [BW-1:0] exp_beat(input int b);
    logic [BW-1:0] v = '0;
    int p = (m_per == 0) ? 1 : m_per;
    int s = (m_step < p) ? m_step : 0;
    for (int j = 0; j < ND; j++)
      if (m_mask[j]) v[j*DB +: DB] = mdl_tbl[(j*s + b) % p];
    return v;
  endfunction

  function automatic bit exp_last(input int b);
    int p = (m_per == 0) ? 1 : m_per;
    return (m_np != 0) && (b == m_np * p - 1);
  endfunction

  initial begin
    int k = 0;
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: axis.tready = 1'b1;
        1: axis.tready = ($urandom_range(2, 0) != 0);
        2: axis.tready = (k % 4 == 0) || (k % 4 == 3);
        default: axis.tready = 1'b0;
      endcase
      k++;
    end
  end

  initial begin
    bit            prev_stall = 0;
    logic [BW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!aresetn) prev_stall = 0;
      else begin
        if (prev_stall && (axis.tvalid !== 1'b1 ||
            axis.tdata !== prev_d || axis.tlast !== prev_l))
          stab_err++;
        if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
          q_d.push_back(axis.tdata);
          q_l.push_back(axis.tlast);
          if (axis.tlast === 1'b1) last_cyc = cyc;
        end
        if (done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = (axis.tvalid === 1'b1) && (axis.tready !== 1'b1);
        prev_d = axis.tdata;
        prev_l = axis.tlast;
      end
      cyc++;
    end
  end

  task automatic wr_tbl(input int a, input logic [DB-1:0] d);
    tbl_we = 1'b1;
    tbl_waddr = AW'(a);
    tbl_wdata = d;
    mdl_tbl[a] = d;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic kick(input int per, input int np,
                      input int step, input logic [ND-1:0] mask);
    m_per = per; m_np = np; m_step = step; m_mask = mask;
    q_d.delete(); q_l.delete();
    done_cnt = 0; stab_err = 0;
    period = AW'(per); n_periods = 16'(np);
    lane_step = AW'(step); ch_mask = mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (done_cnt != 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int want, input int budget, output bit ok);
    int n = 0;
    while (q_d.size() < want && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (q_d.size() >= want);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (axis.tvalid !== 1'b0) begin miscompares++;
      $display("FAIL reset_tvalid: got %b want 0", axis.tvalid); end
    vectors++;
    if (axis.tlast !== 1'b0) begin miscompares++;
      $display("FAIL reset_tlast: got %b want 0", axis.tlast); end
    vectors++;
    if (axis.tdata !== '0) begin miscompares++;
      $display("FAIL reset_tdata: got %h want 0", axis.tdata); end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin miscompares++;
      $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sine();
    int lat = 0;
    bit ok;
    for (int i = 0; i < 100; i++)
      wr_tbl(i, 16'($rtoi(32767.0 * $sin(6.283185307179586 * i / 100.0))));
    rdy_mode = 0;
    kick(100, 1, 0, 16'h0001);
    while (axis.tvalid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat != 16) begin miscompares++;
      $display("FAIL sine_latency: got %0d want 16", lat); end
    wait_done(500, ok);
    vectors++;
    if (!ok) begin miscompares++;
      $display("FAIL sine_done: got timeout want done"); end
    vectors++;
    if (q_d.size() != 100) begin miscompares++;
      $display("FAIL sine_beats: got %0d want 100", q_d.size()); end
    foreach (q_d[b]) begin
      vectors++;
      if (q_d[b] !== exp_beat(b) || q_l[b] !== exp_last(b)) begin
        miscompares++;
        $display("FAIL sine_beat%0d: got %h/%b want %h/%b",
                 b, q_d[b], q_l[b], exp_beat(b), exp_last(b));
      end
    end
    vectors++;
    if (done_cyc - last_cyc != 1) begin miscompares++;
      $display("FAIL sine_done_delay: got %0d want 1", done_cyc - last_cyc); end
    vectors++;
    if (done_cnt != 1 || busy !== 1'b0) begin miscompares++;
      $display("FAIL sine_end: got done_cnt=%0d busy=%b want 1/0",
               done_cnt, busy); end
  endtask

  task automatic test_phase();
    logic [BW-1:0] e0 = '0;
    bit ok;
    for (int i = 0; i < 8; i++) wr_tbl(i, 16'(i));
    kick(8, 2, 3, 16'hFFFF);
    wait_done(300, ok);
    vectors++;
    if (!ok || q_d.size() != 16) begin miscompares++;
      $display("FAIL phase_beats: got %0d want 16", q_d.size()); end
    for (int j = 0; j < ND; j++) e0[j*DB +: DB] = 16'((3 * j) % 8);
    vectors++;
    if (q_d.size() == 0 || q_d[0] !== e0) begin miscompares++;
      $display("FAIL phase_beat0: got %h want %h",
               (q_d.size() > 0) ? q_d[0] : '0, e0); end
    foreach (q_d[b]) begin
      vectors++;
      if (q_d[b] !== exp_beat(b) || q_l[b] !== exp_last(b)) begin
        miscompares++;
        $display("FAIL phase_beat%0d: got %h/%b want %h/%b",
                 b, q_d[b], q_l[b], exp_beat(b), exp_last(b));
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    for (int it = 0; it < 3; it++) begin
      int per  = $urandom_range(20, 1);
      int np   = $urandom_range(3, 1);
      int step = $urandom_range(25, 0);
      logic [ND-1:0] mask = ND'($urandom);
      for (int i = 0; i < 20; i++) wr_tbl(i, 16'($urandom));
      rdy_mode = (it == 0) ? 2 : 1;
      kick(per, np, step, mask);
      wait_done(3000, ok);
      rdy_mode = 0;
      vectors++;
      if (!ok || q_d.size() != np * per) begin miscompares++;
        $display("FAIL stall_beats%0d: got %0d want %0d",
                 it, q_d.size(), np * per); end
      vectors++;
      if (stab_err != 0) begin miscompares++;
        $display("FAIL stall_stable%0d: got %0d changes want 0",
                 it, stab_err); end
      foreach (q_d[b]) begin
        vectors++;
        if (q_d[b] !== exp_beat(b) || q_l[b] !== exp_last(b)) begin
          miscompares++;
          $display("FAIL stall%0d_beat%0d: got %h/%b want %h/%b",
                   it, b, q_d[b], q_l[b], exp_beat(b), exp_last(b));
        end
      end
    end
  endtask

  task automatic test_stop();
    bit ok;
    rdy_mode = 0;
    kick(10, 0, 2, 16'hA5A5);
    wait_beats(37, 200, ok);
    vectors++;
    if (!ok) begin miscompares++;
      $display("FAIL stop_reach37: got %0d want 37", q_d.size()); end
    stop = 1'b1;
    rdy_mode = 3;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rdy_mode = 0;
    wait_done(100, ok);
    vectors++;
    if (!ok || q_d.size() != 38) begin miscompares++;
      $display("FAIL stop_beats: got %0d want 38", q_d.size()); end
    foreach (q_d[b]) begin
      vectors++;
      if (q_d[b] !== exp_beat(b) || q_l[b] !== 1'b0) begin
        miscompares++;
        $display("FAIL stop_beat%0d: got %h/%b want %h/0",
                 b, q_d[b], q_l[b], exp_beat(b));
      end
    end
    vectors++;
    if (busy !== 1'b0 || done_cnt != 1) begin miscompares++;
      $display("FAIL stop_end: got busy=%b done_cnt=%0d want 0/1",
               busy, done_cnt); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    kick(8, 0, 1, 16'hFFFF);
    wait_beats(5, 100, ok);
    aresetn = 1'b0;
    #1;
    vectors++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== '0) begin miscompares++;
      $display("FAIL midreset_out: got v=%b d=%h want 0/0",
               axis.tvalid, axis.tdata); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++;
      $display("FAIL midreset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) wr_tbl(i, 16'($urandom));
    kick(8, 0, 1, 16'hFFFF);
    wait_beats(1, 64, ok);
    vectors++;
    if (!ok || q_d[0] !== exp_beat(0) || q_l[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_restart: got %h want %h",
               ok ? q_d[0] : '0, exp_beat(0));
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(50, ok);
    vectors++;
    if (!ok) begin miscompares++;
      $display("FAIL midreset_done: got timeout want done"); end
  endtask

  task automatic test_misc();
    bit ok;
    kick(8, 1, 1, 16'hFFFF);
    wait_beats(2, 64, ok);
    period = 7'd5; lane_step = '0; ch_mask = 16'h0001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, ok);
    vectors++;
    if (!ok || q_d.size() != 8) begin miscompares++;
      $display("FAIL ignstart_beats: got %0d want 8", q_d.size()); end
    foreach (q_d[b]) begin
      vectors++;
      if (q_d[b] !== exp_beat(b) || q_l[b] !== exp_last(b)) begin
        miscompares++;
        $display("FAIL ignstart_beat%0d: got %h want %h",
                 b, q_d[b], exp_beat(b));
      end
    end
    wr_tbl(0, 16'($urandom));
    kick(0, 3, 5, 16'hFFFF);
    wait_done(100, ok);
    vectors++;
    if (!ok || q_d.size() != 3) begin miscompares++;
      $display("FAIL per0_beats: got %0d want 3", q_d.size()); end
    foreach (q_d[b]) begin
      vectors++;
      if (q_d[b] !== {ND{mdl_tbl[0]}} || q_l[b] !== exp_last(b)) begin
        miscompares++;
        $display("FAIL per0_beat%0d: got %h want %h",
                 b, q_d[b], {ND{mdl_tbl[0]}});
      end
    end
    kick(8, 1, 9, 16'hFFFF);
    wait_done(100, ok);
    vectors++;
    if (!ok || q_d.size() != 8) begin miscompares++;
      $display("FAIL step9_beats: got %0d want 8", q_d.size()); end
    foreach (q_d[b]) begin
      vectors++;
      if (q_d[b] !== {ND{mdl_tbl[b]}} || q_d[b] !== exp_beat(b)) begin
        miscompares++;
        $display("FAIL step9_beat%0d: got %h want %h",
                 b, q_d[b], {ND{mdl_tbl[b]}});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sine();
    test_phase();
    test_stall();
    test_stop();
    test_reset_mid_run();
    test_misc();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
